// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the buffered demultiplexer and its channel FIFOs.
package demux_pkg;

  localparam int LARGURA_PADRAO = 16;
  localparam int CANAIS_PADRAO  = 4;

  // Ceiling log2 for tools without $clog2; clog2(1) = 0.
  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < valor) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fila_n_fila_canal.sv
// Per-channel FIFO: extra pointer MSB distinguishes full from empty; head reads as zero when empty.
module fila_canal
  import demux_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [LARGURA-1:0] dado_in,
  input  logic               pop,
  output logic [LARGURA-1:0] dado_out,
  output logic               vazio,
  output logic               cheio
);

  localparam int PW = clog2(PROFUNDIDADE);

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PW:0]        wr_ptr;
  logic [PW:0]        rd_ptr;
  logic               push_ef;
  logic               pop_ef;

  assign vazio   = (wr_ptr == rd_ptr);
  assign cheio   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push_ef = push && !cheio;
  assign pop_ef  = pop && !vazio;

  assign dado_out = vazio ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ef) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_ef)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves past it.
  always_ff @(posedge clk) begin
    if (push_ef) mem[wr_ptr[PW-1:0]] <= dado_in;
  end

endmodule

// File: rtl/demux_fila_n.sv
// Buffered N-way demultiplexer: routes each accepted word to one channel FIFO or broadcasts to all.
module demux_fila_n
  import demux_pkg::*;
#(
  parameter int  LARGURA      = LARGURA_PADRAO,
  parameter int  CANAIS       = CANAIS_PADRAO,
  parameter int  PROFUNDIDADE = 2,
  localparam int SEL_W        = clog2(CANAIS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LARGURA-1:0]        entrada_dados,
  input  logic [SEL_W-1:0]          entrada_sel,
  input  logic                      entrada_difusao,
  input  logic                      entrada_valido,
  output logic                      entrada_pronto,
  output logic [CANAIS*LARGURA-1:0] saida_dados,
  output logic [CANAIS-1:0]         saida_valido,
  input  logic [CANAIS-1:0]         saida_pronto,
  output logic                      erro_sel,
  output logic [15:0]               contagem_descartes
);

  // Handshake: a word moves on a rising edge where valid && ready. Ready never
  // looks at the same side's valid, and entrada_pronto never looks at saida_pronto,
  // so a full FIFO stays not-ready even in a cycle where it is being drained.

  logic [CANAIS-1:0] cheio;
  logic [CANAIS-1:0] vazio;
  logic [CANAIS-1:0] push;
  logic              sel_no_intervalo;
  logic              descarte;

  assign sel_no_intervalo = ({1'b0, entrada_sel} < (SEL_W+1)'(CANAIS));

  always_comb begin
    push           = '0;
    entrada_pronto = 1'b0;
    descarte       = 1'b0;
    if (entrada_difusao) begin
      entrada_pronto = ~|cheio;
      if (entrada_valido && entrada_pronto) push = '1;
    end else if (sel_no_intervalo) begin
      entrada_pronto = !cheio[entrada_sel];
      if (entrada_valido && entrada_pronto) push[entrada_sel] = 1'b1;
    end else begin
      entrada_pronto = 1'b1;
      descarte       = entrada_valido;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erro_sel           <= 1'b0;
      contagem_descartes <= '0;
    end else begin
      erro_sel <= descarte;
      if (descarte && (contagem_descartes != 16'hFFFF))
        contagem_descartes <= contagem_descartes + 16'd1;
    end
  end

  for (genvar k = 0; k < CANAIS; k++) begin : g_canal
    fila_canal #(
      .LARGURA      (LARGURA),
      .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
      .clk      (clk),
      .reset    (reset),
      .push     (push[k]),
      .dado_in  (entrada_dados),
      .pop      (saida_pronto[k]),
      .dado_out (saida_dados[k*LARGURA +: LARGURA]),
      .vazio    (vazio[k]),
      .cheio    (cheio[k])
    );
  end

  assign saida_valido = ~vazio;

endmodule

// File: doc/demux_fila_n.md
Name: demux_fila_n

Overview:
- Parametrised, buffered successor of the 16-bit 4-way demultiplexer.
- Routes each accepted input word to one of CANAIS output channels, or to all channels in broadcast mode.
- Each channel has its own small FIFO with a valid/ready handshake, so a slow consumer stalls only its own channel.
- Sits between a single producer (instruction/data fetch path) and multiple register/memory consumers.

Parameters:
- LARGURA, 16, data word width in bits (>=1).
- CANAIS, 4, number of output channels (2..16; need not be a power of two).
- PROFUNDIDADE, 2, entries per channel FIFO (power of two, >=2).
- SEL_W, $clog2(CANAIS), select width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- entrada_dados  input  LARGURA  data word from the producer.
- entrada_sel  input  SEL_W  destination channel index.
- entrada_difusao  input  1  1 = broadcast to all channels; entrada_sel is ignored.
- entrada_valido  input  1  producer has a word.
- entrada_pronto  output  1  block can accept the word this cycle.
- saida_dados  output  CANAIS*LARGURA  flattened outputs; channel k occupies bits [k*LARGURA +: LARGURA].
- saida_valido  output  CANAIS  per-channel head-of-FIFO valid.
- saida_pronto  input  CANAIS  per-channel consumer ready.
- erro_sel  output  1  one-cycle pulse when a word was dropped because of an out-of-range select.
- contagem_descartes  output  16  saturating count of dropped words.

Behaviour:
- Accept condition: entrada_valido && entrada_pronto on a rising clk edge.
- entrada_pronto is combinational from entrada_sel, entrada_difusao and the FIFO full flags:
  - unicast, sel < CANAIS: pronto = !cheio[sel];
  - broadcast: pronto = AND over k of !cheio[k]; all channels are written in the same cycle, or none are;
  - unicast, sel >= CANAIS: pronto = 1; the word is dropped and no FIFO is written.
- entrada_pronto does not depend on saida_pronto in the same cycle. A full FIFO that is popping this cycle still reports not-ready; no pass-through.
- Latency: an accepted word appears at the head of its channel (saida_valido[k]=1) on the next cycle at the earliest.
- Per-channel pop: saida_valido[k] && saida_pronto[k] at the clock edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Push into an empty FIFO while the consumer is ready: the word is visible next cycle and popped one cycle after that.
- saida_valido[k] = !vazio[k].
- saida_dados slice k = head entry when valid, else all zeros. This preserves the zero-on-unselected behaviour of the earlier demux.
- Data must be held stable while saida_valido[k]=1 && saida_pronto[k]=0.
- FIFO pointers are log2(PROFUNDIDADE)+1 bits with wrap-around.
  - full: pointer MSBs differ and the remaining bits are equal.
  - empty: pointers are equal.
- Exactly PROFUNDIDADE words are storable per channel.
- Drops (out-of-range select):
  - erro_sel is registered: it is 1 for exactly the cycle after the drop, else 0.
  - contagem_descartes increments by 1 per drop and saturates at 16'hFFFF.
- Reset (asynchronous, any cycle, including mid-transfer):
  - all FIFOs empty, saida_valido=0, saida_dados=0;
  - erro_sel=0, contagem_descartes=0;
  - in-flight words are lost;
  - entrada_pronto follows the combinational rule, which is 1 for every in-range select after reset.
- No internal state machine beyond the FIFO pointers and the drop logic. Each channel is independent; no cross-channel ordering guarantee except for broadcast words, which land in every FIFO on the same cycle.

Decomposition:
- Shared package demux_pkg: default LARGURA and CANAIS constants, and a clog2 helper function for tools lacking $clog2.
- Sub-module fila_canal, instantiated CANAIS times in a generate loop:
  - parameters LARGURA and PROFUNDIDADE;
  - ports: push, dado_in, pop, dado_out, vazio, cheio;
  - dado_out is zero when empty.
- Top level contains the destination decode, the broadcast AND-reduction, and the drop/error logic.

Test Plan:
- Reset, then sel=2, dados=16'hBEEF, valido pulse for one cycle → next cycle saida_valido=4'b0100 and slice 2 = 16'hBEEF; other slices 0.
- Hold saida_pronto[1]=0; push 16'h0001, 16'h0002, 16'h0003 to channel 1 → third push sees entrada_pronto=0. Raise saida_pronto[1] → outputs 0001 then 0002 in order; pronto returns to 1.
- entrada_difusao=1, dados=16'hA5A5 with channel 3 full → not accepted, no FIFO written. Drain channel 3 → word lands in all four channels on the same cycle.
- CANAIS=3, sel=2'b11, one valid word → erro_sel=1 for one cycle, contagem_descartes=1, all saida_valido stay 0. Repeat 70000 drops → counter holds 16'hFFFF.
- Channel 0 holding one word, push and pop on the same cycle for 8 cycles with incrementing data → occupancy stays 1, output sequence strictly in order, no loss.
- Assert reset asynchronously mid-cycle with two channels non-empty → saida_valido=0 and saida_dados=0 immediately, before the next clk edge. After release, entrada_pronto=1.
